serial_subtract_ctrl: RTL and testbench
=======================================

SERIAL_SUBTRACT_CTRL -- requirements
Module: serial_subtract_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal values WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a subtraction; sampled only when ready=1.
REQ-005 a  input  WIDTH  minuend; sampled with start.
REQ-006 b  input  WIDTH  subtrahend; sampled with start.
REQ-007 bin  input  1  borrow-in; sampled with start.
REQ-008 ack  input  1  result consumed; sampled only in DONE.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 busy  output  1  high in RUN only.
REQ-011 done  output  1  high in DONE only.
REQ-012 diff  output  WIDTH  result difference.
REQ-013 bout  output  1  result borrow-out.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; exactly one of ready/busy/done is high at any time.
REQ-015 IDLE & start=1 at an edge: capture a, b; load internal borrow with bin; clear bit counter; go to RUN.
REQ-016 IDLE & start=0: remain in IDLE.
REQ-017 RUN: one bit per clock, LSB first, through one full-subtractor cell.
REQ-017a Cell: d = ai ^ bi ^ brw; brw_next = (~ai & bi) | (~(ai ^ bi) & brw).
REQ-018 RUN: each d shifts into an internal result register from the MSB end; the counter increments by 1 per bit.
REQ-019 After bit WIDTH-1 is processed, the FSM SHALL go to DONE.
REQ-019a On that same edge, diff and bout update to the completed result; this is the only event that changes diff/bout besides reset.
REQ-020 Latency: start sampled at edge 0 -> done=1 after edge WIDTH; exactly WIDTH RUN cycles.
REQ-021 Result: diff = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned).
REQ-022 DONE: done, diff and bout hold stable until ack=1 is sampled; then go to IDLE.
REQ-022a After leaving DONE, diff/bout retain the last result.
REQ-023 start while not IDLE SHALL be ignored (no recapture, no restart).
REQ-023a ack outside DONE SHALL be ignored.
REQ-024 ack=1 and start=1 on the same edge in DONE: go to IDLE only; start is not accepted, because ready=0.
REQ-025 Counter SHALL be ceil(log2(WIDTH))+1 bits wide; no wrap-around occurs within a run.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE: ready=1, busy=0, done=0, diff=0, bout=0, and clear internal borrow, counter and shift registers.
REQ-027 Reset mid-RUN or in DONE SHALL abort the operation; no partial result appears on diff/bout.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy for 8 cycles, then done=1, diff=0x1E, bout=0.
REQ-030 Boundary operands:
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- a=0x80, b=0x00, bin=1 -> diff=0x7F, bout=0.
REQ-031 start re-pulsed with new operands during RUN -> ignored; the result matches the first operands and the latency is still 8.
REQ-032 ack withheld 3 cycles in DONE -> done, diff, bout stable throughout; ack+start together -> IDLE, no new run.
REQ-033 rst_n pulsed low after bit 4 of a run -> ready=1, diff=0, bout=0 immediately; the next start completes correctly.
REQ-034 WIDTH=3, exhaustive over all 128 {a,b,bin} combinations -> every result matches REQ-021 against a reference model.

Source files
------------

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: computes a - b - bin one bit per clock,
// LSB first, through a single full-subtractor cell.
//
// Ports:
//   clk    - clock, all state updates on rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request a subtraction (accepted only while ready)
//   a, b   - minuend / subtrahend, captured with start
//   bin    - borrow-in, captured with start
//   ack    - result consumed (honoured only while done)
//   ready  - high in IDLE
//   busy   - high in RUN
//   done   - high in DONE
//   diff   - completed difference, held until the next completed run
//   bout   - completed borrow-out
module serial_subtract_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Counter must hold WIDTH-1 without wrapping.
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             brw;
    logic [CNT_W-1:0] cnt;

    logic             ai_c;
    logic             bi_c;
    logic             d_c;
    logic             brw_next_c;
    logic             last_bit_c;

    // Full-subtractor cell operating on the current LSBs of the operand shifters.
    assign ai_c       = a_sh[0];
    assign bi_c       = b_sh[0];
    assign d_c        = ai_c ^ bi_c ^ brw;
    assign brw_next_c = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & brw);
    assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // ack wins; a simultaneous start is dropped since ready is low.
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_next == IDLE);
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Serial datapath: operands shift right, result bits enter from the MSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_sh <= a;
                b_sh <= b;
                r_sh <= '0;
                brw  <= bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                r_sh <= {d_c, r_sh[WIDTH-1:1]};
                brw  <= brw_next_c;
                cnt  <= cnt + CNT_W'(1);
                // Publish only a completed result.
                if (last_bit_c) begin
                    diff <= {d_c, r_sh[WIDTH-1:1]};
                    bout <= brw_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed bench for serial_subtract_ctrl: an 8-bit instance for the directed
// vectors and control scenarios, and a 3-bit instance swept exhaustively.
module tb_serial_subtract_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       ack8;
    logic       ready8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       bin3;
    logic       ack3;
    logic       ready3;
    logic       busy3;
    logic       done3;
    logic [2:0] diff3;
    logic       bout3;

    int n_chk;
    int n_pass;

    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .ack   (ack8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtract_ctrl #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .bin   (bin3),
        .ack   (ack3),
        .ready (ready3),
        .busy  (busy3),
        .done  (done3),
        .diff  (diff3),
        .bout  (bout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one 8-bit operation. Optionally re-pulses start with other operands
    // and holds ack high mid-run. Returns the result and the busy cycle count;
    // leaves the DUT in DONE (ack not yet given).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input bit disturb,
                        output logic [7:0] d, output logic bo, output int nbusy);
        int guard;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(negedge clk);
        start8 = 1'b0;
        nbusy = 0;
        guard = 0;
        while (!done8 && guard < 40) begin
            if (busy8) nbusy++;
            if (disturb && guard == 2) begin
                start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; ack8 = 1'b1;
            end else begin
                start8 = 1'b0; ack8 = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start8 = 1'b0;
        ack8   = 1'b0;
        if (!done8) chk("done8_timeout", 32'(done8), 32'd1);
        d  = diff8;
        bo = bout8;
    endtask

    task automatic ack8_cycle();
        ack8 = 1'b1;
        @(negedge clk);
        ack8 = 1'b0;
    endtask

    logic [7:0] d;
    logic       bo;
    int         nb;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; ack8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0; ack3 = 1'b0;

        #12;
        chk("rst_ready", 32'(ready8), 32'd1);
        chk("rst_busy",  32'(busy8),  32'd0);
        chk("rst_done",  32'(done8),  32'd0);
        chk("rst_diff",  32'(diff8),  32'd0);
        chk("rst_bout",  32'(bout8),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic vector with latency check.
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, d, bo, nb);
        chk("v5a_busy", 32'(nb), 32'd8);
        chk("v5a_diff", 32'(d),  32'h1E);
        chk("v5a_bout", 32'(bo), 32'd0);
        chk("v5a_flags", {29'd0, ready8, busy8, done8}, 32'b001);
        ack8_cycle();
        chk("v5a_idle", 32'(ready8), 32'd1);
        chk("v5a_keep", 32'(diff8),  32'h1E);

        // Boundary operands.
        run8(8'h00, 8'h01, 1'b0, 1'b0, d, bo, nb);
        chk("b0_res", {23'd0, bo, d}, {23'd0, 1'b1, 8'hFF});
        ack8_cycle();
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, d, bo, nb);
        chk("b1_res", {23'd0, bo, d}, {23'd0, 1'b1, 8'hFF});
        ack8_cycle();
        run8(8'h80, 8'h00, 1'b1, 1'b0, d, bo, nb);
        chk("b2_res", {23'd0, bo, d}, {23'd0, 1'b0, 8'h7F});
        ack8_cycle();
        run8(8'h10, 8'h20, 1'b1, 1'b0, d, bo, nb);
        chk("b3_res", {23'd0, bo, d}, {23'd0, 1'b1, 8'hEF});

        // Result stays put with ack withheld for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_state", {20'd0, ready8, busy8, done8, bout8, diff8},
                {20'd0, 3'b001, 1'b1, 8'hEF});
        end
        // ack and start together: return to IDLE without starting.
        ack8 = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        ack8 = 1'b0; start8 = 1'b0;
        chk("ackstart_idle", {29'd0, ready8, busy8, done8}, 32'b100);
        @(negedge clk);
        chk("ackstart_norun", {29'd0, ready8, busy8, done8}, 32'b100);

        // Start re-pulsed and ack asserted mid-run are both ignored.
        run8(8'h33, 8'h11, 1'b0, 1'b1, d, bo, nb);
        chk("rep_busy", 32'(nb), 32'd8);
        chk("rep_res", {23'd0, bo, d}, {23'd0, 1'b0, 8'h22});
        ack8_cycle();

        // Reset after bit 4 of a run: immediate return to IDLE with cleared result.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {21'd0, ready8, busy8, done8, bout8, diff8}, {21'd0, 3'b100, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'hC8, 8'h64, 1'b1, 1'b0, d, bo, nb);
        chk("post_rst_busy", 32'(nb), 32'd8);
        chk("post_rst_res", {23'd0, bo, d}, {23'd0, 1'b0, 8'h63});
        ack8_cycle();

        // Exhaustive 3-bit sweep against an arithmetic reference.
        for (int k = 0; k < 128; k++) begin
            logic [6:0] v;
            logic [2:0] ea;
            logic [2:0] eb;
            logic       ebin;
            int         r;
            int         g;
            v    = 7'(k);
            ea   = v[6:4];
            eb   = v[3:1];
            ebin = v[0];
            r    = int'(ea) - int'(eb) - int'(ebin);
            @(negedge clk);
            start3 = 1'b1; a3 = ea; b3 = eb; bin3 = ebin;
            @(negedge clk);
            start3 = 1'b0;
            g = 0;
            while (!done3 && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk($sformatf("w3_%0d_%0d_%0d", ea, eb, ebin), {28'd0, done3, bout3, diff3},
                {28'd0, 1'b1, (r < 0) ? 1'b1 : 1'b0, 3'(r)});
            ack3 = 1'b1;
            @(negedge clk);
            ack3 = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
